// File: rtl/mux_arb_rr.sv
// N-channel registered mux with valid/ready handshake; fixed-select or round-robin.
// One-entry output register supports full throughput with simultaneous consume and load.
module mux_arb_rr #(
   parameter int WIDTH  = 4,
   parameter int NUM_CH = 4,
   parameter int SEL_W  = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    mode,
   input  logic [SEL_W-1:0]        sel,
   input  logic [NUM_CH*WIDTH-1:0] din,
   input  logic [NUM_CH-1:0]       din_valid,
   output logic [NUM_CH-1:0]       din_ready,
   output logic [WIDTH-1:0]        muxOut,
   output logic                    muxOut_valid,
   input  logic                    muxOut_ready,
   output logic [SEL_W-1:0]        grant
);

   logic [WIDTH-1:0] r_data;
   logic             r_valid;
   logic [SEL_W-1:0] r_grant;
   logic [SEL_W-1:0] r_rr_ptr;

   logic             w_load_en;
   logic             w_cand;
   logic             w_xfer;
   logic [SEL_W-1:0] w_ch;
   logic [SEL_W-1:0] w_ptr_nxt;
   logic [WIDTH-1:0] w_data;

   assign w_load_en = !r_valid || muxOut_ready;

   // Round-robin search: first valid at or above the pointer, else first valid below it.
   always_comb begin
      w_cand = 1'b0;
      w_ch   = '0;
      if (!mode) begin
         w_ch = sel;
         for (int c = 0; c < NUM_CH; c++)
            if (int'(sel) == c) w_cand = din_valid[c];
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (!w_cand && c >= int'(r_rr_ptr) && din_valid[c]) begin
               w_cand = 1'b1;
               w_ch   = SEL_W'(c);
            end
         end
         for (int c = 0; c < NUM_CH; c++) begin
            if (!w_cand && c < int'(r_rr_ptr) && din_valid[c]) begin
               w_cand = 1'b1;
               w_ch   = SEL_W'(c);
            end
         end
      end
   end

   always_comb begin
      w_data = '0;
      for (int c = 0; c < NUM_CH; c++)
         if (int'(w_ch) == c) w_data = din[c*WIDTH +: WIDTH];
   end

   assign w_xfer    = w_cand && w_load_en;
   assign w_ptr_nxt = (int'(w_ch) == NUM_CH-1) ? '0 : w_ch + 1'b1;

   always_comb begin
      din_ready = '0;
      for (int c = 0; c < NUM_CH; c++)
         if (reset && w_xfer && int'(w_ch) == c) din_ready[c] = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_data   <= '0;
         r_valid  <= 1'b0;
         r_grant  <= '0;
         r_rr_ptr <= '0;
      end else if (w_xfer) begin
         r_data  <= w_data;
         r_grant <= w_ch;
         r_valid <= 1'b1;
         if (mode) r_rr_ptr <= w_ptr_nxt;
      end else if (r_valid && muxOut_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign muxOut       = r_data;
   assign muxOut_valid = r_valid;
   assign grant        = r_grant;

endmodule

// File: tb/tb_mux_arb_rr.sv
// Directed bench for mux_arb_rr: 4x4 default instance plus an 8-bit 2-channel instance.
module tb_mux_arb_rr;

   logic        clk = 1'b0;
   logic        reset;
   logic        mode;
   logic [1:0]  sel;
   logic [15:0] din;
   logic [3:0]  din_valid;
   logic [3:0]  din_ready;
   logic [3:0]  muxOut;
   logic        muxOut_valid;
   logic        muxOut_ready;
   logic [1:0]  grant;

   logic        p_mode;
   logic [0:0]  p_sel;
   logic [15:0] p_din;
   logic [1:0]  p_din_valid;
   logic [1:0]  p_din_ready;
   logic [7:0]  p_muxOut;
   logic        p_muxOut_valid;
   logic        p_muxOut_ready;
   logic [0:0]  p_grant;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mux_arb_rr #(.WIDTH(4), .NUM_CH(4), .SEL_W(2)) u_dut (
      .clk(clk), .reset(reset), .mode(mode), .sel(sel), .din(din),
      .din_valid(din_valid), .din_ready(din_ready), .muxOut(muxOut),
      .muxOut_valid(muxOut_valid), .muxOut_ready(muxOut_ready), .grant(grant)
   );

   mux_arb_rr #(.WIDTH(8), .NUM_CH(2), .SEL_W(1)) u_dut8 (
      .clk(clk), .reset(reset), .mode(p_mode), .sel(p_sel), .din(p_din),
      .din_valid(p_din_valid), .din_ready(p_din_ready), .muxOut(p_muxOut),
      .muxOut_valid(p_muxOut_valid), .muxOut_ready(p_muxOut_ready), .grant(p_grant)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic [3:0] d, input logic [1:0] g, input logic v);
      chk({tag, ".data"},  32'(muxOut), 32'(d));
      chk({tag, ".grant"}, 32'(grant), 32'(g));
      chk({tag, ".valid"}, 32'(muxOut_valid), 32'(v));
   endtask

   initial begin
      reset = 1'b0; mode = 1'b1; sel = 2'd0; din = 16'h0; din_valid = 4'b1111; muxOut_ready = 1'b0;
      p_mode = 1'b0; p_sel = 1'b0; p_din = 16'h0; p_din_valid = 2'b00; p_muxOut_ready = 1'b0;
      #2;
      chk_out("rst", 4'h0, 2'd0, 1'b0);
      chk("rst.din_ready", 32'(din_ready), 32'h0);
      chk("rst.p_valid", 32'(p_muxOut_valid), 32'h0);
      din_valid = 4'b0000;
      #1 reset = 1'b1;

      // fixed select
      tick;
      mode = 1'b0; sel = 2'd2; din = 16'h4521; din_valid = 4'b0100; muxOut_ready = 1'b1;
      #1 chk("fix.din_ready", 32'(din_ready), 32'b0100);
      tick;
      chk_out("fix.load", 4'h5, 2'd2, 1'b1);
      sel = 2'd3;
      #1 chk("fix.nocand.din_ready", 32'(din_ready), 32'h0);
      tick;
      chk_out("fix.nocand", 4'h5, 2'd2, 1'b0);

      // round-robin fairness, pointer still 0 after fixed mode
      mode = 1'b1; din = 16'h4321; din_valid = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         #1 chk($sformatf("rr%0d.din_ready", k), 32'(din_ready), 32'(4'b0001 << (k % 4)));
         tick;
         chk_out($sformatf("rr%0d", k), 4'((k % 4) + 1), 2'(k % 4), 1'b1);
      end

      // skip: pointer is 1, only ch3/ch0 valid
      din_valid = 4'b1001;
      #1 chk("skip.din_ready", 32'(din_ready), 32'b1000);
      tick;
      chk_out("skip.a", 4'h4, 2'd3, 1'b1);
      #1 chk("skip.wrap.din_ready", 32'(din_ready), 32'b0001);
      tick;
      chk_out("skip.b", 4'h1, 2'd0, 1'b1);

      // backpressure, pointer is 1
      muxOut_ready = 1'b0; din_valid = 4'b1111;
      for (int k = 0; k < 3; k++) begin
         #1 chk($sformatf("bp%0d.din_ready", k), 32'(din_ready), 32'h0);
         tick;
         chk_out($sformatf("bp%0d", k), 4'h1, 2'd0, 1'b1);
      end
      muxOut_ready = 1'b1;
      #1 chk("bp.rel.din_ready", 32'(din_ready), 32'b0010);
      tick;
      chk_out("bp.rel", 4'h2, 2'd1, 1'b1);

      // idle drains output, pointer (2) unchanged
      din_valid = 4'b0000;
      tick;
      chk_out("idle", 4'h2, 2'd1, 1'b0);
      din_valid = 4'b1111;
      tick;
      chk_out("idle.ptr", 4'h3, 2'd2, 1'b1);

      // pointer (3) persists across a fixed-mode transfer
      mode = 1'b0; sel = 2'd0;
      tick;
      chk_out("sw.fix", 4'h1, 2'd0, 1'b1);
      mode = 1'b1;
      tick;
      chk_out("sw.rr", 4'h4, 2'd3, 1'b1);

      // asynchronous reset mid-stream while holding 4'hA
      mode = 1'b0; sel = 2'd1; din = 16'h43A1; din_valid = 4'b0010;
      tick;
      chk_out("pre.rst", 4'hA, 2'd1, 1'b1);
      muxOut_ready = 1'b0;
      #2 reset = 1'b0;
      #1;
      chk_out("mid.rst", 4'h0, 2'd0, 1'b0);
      chk("mid.rst.din_ready", 32'(din_ready), 32'h0);
      reset = 1'b1; mode = 1'b1; din_valid = 4'b1111; muxOut_ready = 1'b1;
      #1 chk("post.rst.din_ready", 32'(din_ready), 32'b0001);
      tick;
      chk_out("post.rst", 4'h1, 2'd0, 1'b1);

      // 8-bit, 2-channel instance
      p_mode = 1'b0; p_sel = 1'b1; p_din = 16'hC35A; p_din_valid = 2'b10; p_muxOut_ready = 1'b1;
      #1 chk("p8.din_ready", 32'(p_din_ready), 32'b10);
      tick;
      chk("p8.data", 32'(p_muxOut), 32'hC3);
      chk("p8.grant", 32'(p_grant), 32'h1);
      chk("p8.valid", 32'(p_muxOut_valid), 32'h1);
      p_mode = 1'b1; p_din_valid = 2'b11;
      tick;
      chk("p8.rr.data", 32'(p_muxOut), 32'h5A);
      chk("p8.rr.grant", 32'(p_grant), 32'h0);
      tick;
      chk("p8.rr.wrap", 32'(p_grant), 32'h1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
